uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Byte-wide UART transmitter (8 data bits, no parity, 1 stop bit, LSB first) producing a serial line from a parallel byte on a single start strobe. It sits between on-chip logic and a TX pad or a loopback receiver. Bit timing comes from a fixed clocks-per-bit divider; there is no separate baud-rate input.

## Interface
- CLKS_PER_BIT, default 2: clock cycles per serial bit, minimum 1. The default suits fast simulation; synthesis overrides it, e.g. 868 for 100 MHz at 115200 baud.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- start  input  1  transmit request, level-sampled each rising edge; accepted only when idle.
- data_in  input  8  byte to send, captured on the accepting edge.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  high from the accepting edge until the stop bit completes; registered.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - start=1 at an edge: latch data_in into the shift register, clear bit counter and baud counter, set tx=0, busy=1, go to START.
- START:
  - Hold tx=0 for CLKS_PER_BIT cycles, then drive tx=data[0] and go to DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, bits 0..7 in order.
  - After bit 7's period, drive tx=1 and go to STOP.
- STOP:
  - Hold tx=1 for CLKS_PER_BIT cycles, then busy=0 and go to IDLE.
- start while busy=1 is ignored, not queued.
- data_in changes after acceptance do not affect the frame in flight.
- A start held high continuously produces back-to-back frames.
  - In the cycle the FSM returns to IDLE, start is not yet examined; acceptance happens at the next edge.
  - This gives exactly one idle-high cycle between frames.
- Baud counter: width max(1, clog2(CLKS_PER_BIT)); counts 0..CLKS_PER_BIT-1, wraps at terminal count.
- Bit counter: 3 bits.
- No overflow or other error conditions exist.

## Timing
- Reset: rst=1 at an edge forces state=IDLE, tx=1, busy=0, counters=0.
  - Applies mid-frame too: the frame aborts immediately, tx returns high on that edge, and no partial bits follow.
  - rst has priority over start in the same cycle.
- Let edge A be the edge where start is accepted.
  - After A: tx=0, busy=1.
  - Data bit k appears after edge A+(1+k)·CLKS_PER_BIT.
  - Stop bit appears after edge A+9·CLKS_PER_BIT.
  - busy falls after edge A+10·CLKS_PER_BIT. Total busy time is exactly 10·CLKS_PER_BIT cycles.
- tx and busy are glitch-free flop outputs, with no combinational path from inputs.
- A one-cycle start pulse is sufficient.

## Test plan
- Reset: hold rst=1 for 2 cycles with start=1 -> tx=1, busy=0 throughout; no frame starts.
- Single frame: CLKS_PER_BIT=2, data_in=8'h03, 1-cycle start pulse.
  - tx sampled per bit = 0,1,1,0,0,0,0,0,0,1; each value held 2 cycles.
  - busy high for exactly 20 cycles, then tx=1, busy=0.
- Ignored start: pulse start with data_in=8'hFF during the frame above -> frame still carries 8'h03; no second frame.
- Back-to-back: CLKS_PER_BIT=4, start held high, data_in=8'hA5.
  - First frame bits = 0,1,0,1,0,0,1,0,1,1.
  - One idle-high cycle, then a second identical frame; busy low for exactly 1 cycle between frames.
- Mid-frame reset: assert rst during data bit 3 of a 8'h55 frame -> tx=1, busy=0 on that edge; a new start afterwards sends a complete, correct frame.
- CLKS_PER_BIT=1: send 8'h80 -> tx = 0,0,0,0,0,0,0,0,1,1 on consecutive cycles; busy high for 10 cycles.

Source files
------------

// File: rtl/uart_transmitter.sv
// Byte-wide UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first.
// Bit timing is a fixed CLKS_PER_BIT clock divider. tx and busy are flop outputs.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shift_reg;
  logic              tx_n, busy_n;
  logic              load, shift_en;
  logic              baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // Control state, counters and registered line outputs; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx       <= tx_n;
      busy     <= busy_n;
    end
  end

  // Payload shift register: loaded on acceptance, shifted right after each data bit.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_reg <= data_in;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // Next-state and next-output logic; each bit is held until the baud counter wraps.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    tx_n       = tx;
    busy_n     = busy;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (start) begin
          load       = 1'b1;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
          state_n    = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          tx_n       = shift_reg[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            tx_n      = shift_reg[1];
            shift_en  = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_n = '0;
          tx_n       = 1'b1;
          busy_n     = 1'b0;
          state_n    = IDLE;
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (CLKS_PER_BIT = 2, 4, 1) checked
// every cycle against a frame-level model, plus literal frame patterns.
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cpb [3] = '{2, 4, 1};

  logic [2:0] rst_v;
  logic [2:0] start_v;
  logic [7:0] din_v [3];
  logic       tx0, tx1, tx2, busy0, busy1, busy2;
  logic [2:0] tx_w, busy_w;

  assign tx_w   = {tx2, tx1, tx0};
  assign busy_w = {busy2, busy1, busy0};

  uart_transmitter #(.CLKS_PER_BIT(2)) dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .data_in(din_v[0]), .tx(tx0), .busy(busy0));
  uart_transmitter #(.CLKS_PER_BIT(4)) dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .data_in(din_v[1]), .tx(tx1), .busy(busy1));
  uart_transmitter #(.CLKS_PER_BIT(1)) dut2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .data_in(din_v[2]), .tx(tx2), .busy(busy2));

  // Frame-level model: cycles elapsed since acceptance and the accepted byte.
  bit         m_busy [3];
  int         m_t    [3];
  logic [7:0] m_byte [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_t[i]    = 0;
      m_byte[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin
        m_busy[i] = 1'b0;
        m_t[i]    = 0;
      end else if (m_busy[i]) begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == 10 * cpb[i]) m_busy[i] = 1'b0;
      end else if (start_v[i]) begin
        m_busy[i] = 1'b1;
        m_t[i]    = 0;
        m_byte[i] = din_v[i];
      end
    end
  end

  // Frame slot k = t / CLKS_PER_BIT: 0 is start, 1..8 data bits, 9 stop.
  function automatic logic exp_tx(input int i);
    int k;
    if (!m_busy[i]) return 1'b1;
    k = m_t[i] / cpb[i];
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[i][k-1];
  endfunction

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;
  logic [19:0] s20;
  logic [9:0]  f1, f2;
  int   bcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_tx%0d", i), 32'(tx_w[i]), 32'(exp_tx(i)));
        check($sformatf("model_busy%0d", i), 32'(busy_w[i]), 32'(m_busy[i]));
      end
    end
  endtask

  initial begin
    rst_v   = 3'b111;
    start_v = 3'b111;
    for (int i = 0; i < 3; i++) din_v[i] = 8'h5A;

    // Reset held two cycles with start high: line stays idle.
    tick();
    check("rst1_tx", 32'(tx_w), 32'(3'b111));
    check("rst1_busy", 32'(busy_w), 32'(3'b000));
    tick();
    check("rst2_tx", 32'(tx_w), 32'(3'b111));
    check("rst2_busy", 32'(busy_w), 32'(3'b000));
    rst_v   = 3'b000;
    start_v = 3'b000;
    chk_en  = 1'b1;
    tick();
    tick();
    check("idle_after_rst", 32'(busy_w), 32'(3'b000));

    // Single 8'h03 frame at 2 clocks/bit, with an ignored start mid-frame.
    din_v[0] = 8'h03;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    s20[0] = tx_w[0];
    bcnt   = int'(busy_w[0]);
    for (int j = 1; j < 20; j++) begin
      if (j == 6) begin
        start_v[0] = 1'b1;
        din_v[0]   = 8'hFF;
      end
      if (j == 7) start_v[0] = 1'b0;
      tick();
      s20[j] = tx_w[0];
      bcnt   = bcnt + int'(busy_w[0]);
    end
    check("frame03_bits", 32'(s20), 32'(20'hC003C));
    check("frame03_busy_cycles", 32'(bcnt), 32'd20);
    tick();
    check("frame03_end_busy", 32'(busy_w[0]), 32'd0);
    check("frame03_end_tx", 32'(tx_w[0]), 32'd1);
    repeat (4) tick();
    check("no_second_frame", 32'(busy_w[0]), 32'd0);

    // Back-to-back 8'hA5 frames at 4 clocks/bit with start held high.
    din_v[1]   = 8'hA5;
    start_v[1] = 1'b1;
    tick();
    for (int t = 0; t < 82; t++) begin
      if (t < 40 && (t % 4) == 1) f1[t/4] = tx_w[1];
      if (t >= 41 && t < 81 && ((t - 41) % 4) == 1) f2[(t-41)/4] = tx_w[1];
      if (t == 40) begin
        check("gap_busy", 32'(busy_w[1]), 32'd0);
        check("gap_tx", 32'(tx_w[1]), 32'd1);
      end
      if (t == 41) check("second_start_busy", 32'(busy_w[1]), 32'd1);
      if (t == 60) start_v[1] = 1'b0;
      tick();
    end
    check("b2b_frame1", 32'(f1), 32'(10'h34A));
    check("b2b_frame2", 32'(f2), 32'(10'h34A));
    check("b2b_end_busy", 32'(busy_w[1]), 32'd0);

    // Reset during data bit 3 of an 8'h55 frame, then a clean frame.
    din_v[0]   = 8'h55;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (8) tick();
    rst_v[0] = 1'b1;
    tick();
    check("midrst_tx", 32'(tx_w[0]), 32'd1);
    check("midrst_busy", 32'(busy_w[0]), 32'd0);
    rst_v[0] = 1'b0;
    tick();
    check("midrst_stays_idle", 32'(busy_w[0]), 32'd0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if ((t % 2) == 1) f1[t/2] = tx_w[0];
      tick();
    end
    check("after_rst_frame55", 32'(f1), 32'(10'h2AA));
    check("after_rst_end_busy", 32'(busy_w[0]), 32'd0);

    // 8'h80 at 1 clock/bit.
    din_v[2]   = 8'h80;
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    f1[0] = tx_w[2];
    bcnt  = int'(busy_w[2]);
    for (int j = 1; j < 10; j++) begin
      tick();
      f1[j] = tx_w[2];
      bcnt  = bcnt + int'(busy_w[2]);
    end
    check("cpb1_frame80", 32'(f1), 32'(10'h300));
    check("cpb1_busy_cycles", 32'(bcnt), 32'd10);
    tick();
    check("cpb1_end_busy", 32'(busy_w[2]), 32'd0);

    // Randomized starts, bytes and occasional resets, checked by the model.
    for (int i = 0; i < 3; i++) begin
      repeat (500) begin
        start_v[i] = ($urandom_range(0, 3) == 0);
        din_v[i]   = 8'($urandom);
        rst_v[i]   = ($urandom_range(0, 149) == 0);
        tick();
      end
      start_v[i] = 1'b0;
      rst_v[i]   = 1'b0;
    end
    repeat (50) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
